// File: rtl/fp_add_arbiter.sv
// rtl/fp_add_arbiter.sv - round-robin shared signed fixed-point adder with a one-slot result register
module fp_add_arbiter #(
  parameter int N_REQ = 4,
  parameter int IDW   = 2,
  parameter int WI    = 8,
  parameter int WF    = 8,
  parameter int SAT   = 0,
  parameter int CNTW  = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_REQ-1:0]        req_valid,
  output logic [N_REQ-1:0]        req_ready,
  input  logic [N_REQ*(WI+WF)-1:0] req_a,
  input  logic [N_REQ*(WI+WF)-1:0] req_b,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [WI+WF-1:0]        rsp_sum,
  output logic                    rsp_ovf,
  output logic [IDW-1:0]          rsp_id,
  output logic [CNTW-1:0]         ovf_cnt
);
  localparam int W = WI + WF;

  logic [IDW-1:0] ptr;
  logic [IDW-1:0] gnt;
  logic           found;
  logic           can_accept;
  logic           grant_en;
  logic           accept;
  logic [W-1:0]   a_op;
  logic [W-1:0]   b_op;
  logic [W:0]     full;
  logic           ovf;
  logic [W-1:0]   sum;

  // Scan order starts at ptr and wraps; position k in the scan is index (ptr+k) mod N_REQ.
  always_comb begin
    found = 1'b0;
    gnt   = '0;
    for (int k = 0; k < N_REQ; k++) begin
      for (int i = 0; i < N_REQ; i++) begin
        if (!found && req_valid[i] &&
            ((int'(ptr) + k == i) || (int'(ptr) + k == i + N_REQ))) begin
          found = 1'b1;
          gnt   = IDW'(i);
        end
      end
    end
  end

  assign can_accept = ~rsp_valid | rsp_ready;
  assign grant_en   = ~rst & can_accept & found;

  always_comb begin
    req_ready = '0;
    a_op      = '0;
    b_op      = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (gnt == IDW'(i)) begin
        req_ready[i] = grant_en;
        a_op         = req_a[i*W +: W];
        b_op         = req_b[i*W +: W];
      end
    end
  end

  assign accept = |(req_valid & req_ready);

  // One guard bit keeps the true sign; overflow shows as a sign flip between like-signed operands.
  assign full = {a_op[W-1], a_op} + {b_op[W-1], b_op};
  assign ovf  = (a_op[W-1] == b_op[W-1]) && (full[W-1] != a_op[W-1]);

  always_comb begin
    sum = full[W-1:0];
    if (SAT != 0 && ovf) begin
      sum = a_op[W-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid <= 1'b0;
      rsp_sum   <= '0;
      rsp_ovf   <= 1'b0;
      rsp_id    <= '0;
      ovf_cnt   <= '0;
      ptr       <= '0;
    end else if (accept) begin
      rsp_valid <= 1'b1;
      rsp_sum   <= sum;
      rsp_ovf   <= ovf;
      rsp_id    <= gnt;
      ptr       <= (gnt == IDW'(N_REQ - 1)) ? '0 : gnt + IDW'(1);
      if (ovf && ovf_cnt != {CNTW{1'b1}}) begin
        ovf_cnt <= ovf_cnt + CNTW'(1);
      end
    end else if (rsp_ready) begin
      rsp_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_fp_add_arbiter.sv
// tb/tb_fp_add_arbiter.sv - directed bench; wrap/CNTW=16 instance u0 and clamp/CNTW=4 instance u1 share stimulus
module tb_fp_add_arbiter;
  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req_valid;
  logic [63:0] req_a;
  logic [63:0] req_b;
  logic        rsp_ready;

  logic [3:0]  req_ready0, req_ready1;
  logic        rsp_valid0, rsp_valid1;
  logic [15:0] rsp_sum0, rsp_sum1;
  logic        rsp_ovf0, rsp_ovf1;
  logic [1:0]  rsp_id0, rsp_id1;
  logic [15:0] ovf_cnt0;
  logic [3:0]  ovf_cnt1;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  fp_add_arbiter #(.N_REQ(4), .IDW(2), .WI(8), .WF(8), .SAT(0), .CNTW(16)) u0 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready0),
    .req_a(req_a), .req_b(req_b), .rsp_valid(rsp_valid0), .rsp_ready(rsp_ready),
    .rsp_sum(rsp_sum0), .rsp_ovf(rsp_ovf0), .rsp_id(rsp_id0), .ovf_cnt(ovf_cnt0)
  );

  fp_add_arbiter #(.N_REQ(4), .IDW(2), .WI(8), .WF(8), .SAT(1), .CNTW(4)) u1 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready1),
    .req_a(req_a), .req_b(req_b), .rsp_valid(rsp_valid1), .rsp_ready(rsp_ready),
    .rsp_sum(rsp_sum1), .rsp_ovf(rsp_ovf1), .rsp_id(rsp_id1), .ovf_cnt(ovf_cnt1)
  );

  task automatic set_ab(input int i, input logic [15:0] a, input logic [15:0] b);
    req_a[i*16 +: 16] = a;
    req_b[i*16 +: 16] = b;
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; req_valid = 4'b1111; rsp_ready = 1'b1; req_a = '0; req_b = '0;
    step();
    #1;
    total++; if (req_ready0 !== 4'b0000) begin bad++; $display("FAIL reset_ready0 got=%b exp=0000", req_ready0); end
    total++; if (req_ready1 !== 4'b0000) begin bad++; $display("FAIL reset_ready1 got=%b exp=0000", req_ready1); end
    step();
    total++; if (rsp_valid0 !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", rsp_valid0); end
    total++; if (rsp_sum0 !== 16'h0000 || rsp_id0 !== 2'd0 || rsp_ovf0 !== 1'b0)
      begin bad++; $display("FAIL reset_slot got sum=%h id=%0d ovf=%b exp 0/0/0", rsp_sum0, rsp_id0, rsp_ovf0); end
    total++; if (ovf_cnt0 !== 16'd0) begin bad++; $display("FAIL reset_cnt got=%0d exp=0", ovf_cnt0); end
    req_valid = 4'b0000;
    rst = 1'b0;
  endtask

  task automatic test_single();
    set_ab(2, 16'h0180, 16'h0240);
    req_valid = 4'b0100; rsp_ready = 1'b1;
    #1;
    total++; if (req_ready0 !== 4'b0100) begin bad++; $display("FAIL single_ready got=%b exp=0100", req_ready0); end
    step();
    req_valid = 4'b0000;
    total++; if (rsp_valid0 !== 1'b1 || rsp_sum0 !== 16'h03C0 || rsp_id0 !== 2'd2 || rsp_ovf0 !== 1'b0)
      begin bad++; $display("FAIL single_rsp got v=%b sum=%h id=%0d ovf=%b exp 1/03c0/2/0", rsp_valid0, rsp_sum0, rsp_id0, rsp_ovf0); end
    step();
    total++; if (rsp_valid0 !== 1'b0 || rsp_sum0 !== 16'h03C0 || rsp_id0 !== 2'd2)
      begin bad++; $display("FAIL drain_hold got v=%b sum=%h id=%0d exp 0/03c0/2", rsp_valid0, rsp_sum0, rsp_id0); end
  endtask

  task automatic test_round_robin();
    rst = 1'b1; step(); rst = 1'b0;
    for (int i = 0; i < 4; i++) set_ab(i, 16'(i * 256), 16'h0010);
    req_valid = 4'b1111; rsp_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      #1;
      total++; if (req_ready0 !== 4'(1 << (k % 4)))
        begin bad++; $display("FAIL rr_ready[%0d] got=%b exp=%b", k, req_ready0, 4'(1 << (k % 4))); end
      step();
      total++; if (rsp_valid0 !== 1'b1 || rsp_id0 !== 2'(k % 4) || rsp_sum0 !== 16'((k % 4) * 256 + 16))
        begin bad++; $display("FAIL rr_rsp[%0d] got v=%b id=%0d sum=%h exp 1/%0d/%h", k, rsp_valid0, rsp_id0, rsp_sum0, k % 4, 16'((k % 4) * 256 + 16)); end
    end
    req_valid = 4'b0000;
    step();
  endtask

  task automatic test_overflow();
    set_ab(0, 16'h7F00, 16'h0200);
    req_valid = 4'b0001; rsp_ready = 1'b1;
    step();
    total++; if (rsp_sum0 !== 16'h8100 || rsp_ovf0 !== 1'b1)
      begin bad++; $display("FAIL ovf_pos_wrap got sum=%h ovf=%b exp 8100/1", rsp_sum0, rsp_ovf0); end
    total++; if (rsp_sum1 !== 16'h7FFF || rsp_ovf1 !== 1'b1 || rsp_valid1 !== 1'b1)
      begin bad++; $display("FAIL ovf_pos_sat got sum=%h ovf=%b v=%b exp 7fff/1/1", rsp_sum1, rsp_ovf1, rsp_valid1); end
    set_ab(0, 16'h8000, 16'hFF00);
    step();
    req_valid = 4'b0000;
    total++; if (rsp_sum0 !== 16'h7F00 || rsp_ovf0 !== 1'b1)
      begin bad++; $display("FAIL ovf_neg_wrap got sum=%h ovf=%b exp 7f00/1", rsp_sum0, rsp_ovf0); end
    total++; if (rsp_sum1 !== 16'h8000 || rsp_ovf1 !== 1'b1 || rsp_id1 !== 2'd0)
      begin bad++; $display("FAIL ovf_neg_sat got sum=%h ovf=%b id=%0d exp 8000/1/0", rsp_sum1, rsp_ovf1, rsp_id1); end
    total++; if (ovf_cnt0 !== 16'd2 || ovf_cnt1 !== 4'd2)
      begin bad++; $display("FAIL ovf_cnt got=%0d/%0d exp=2/2", ovf_cnt0, ovf_cnt1); end
    step();
  endtask

  task automatic test_backpressure();
    set_ab(0, 16'h0100, 16'h0100);
    set_ab(1, 16'h0011, 16'h0022);
    set_ab(3, 16'h0033, 16'h0044);
    req_valid = 4'b0001; rsp_ready = 1'b0;
    step();
    req_valid = 4'b1010;
    for (int k = 0; k < 5; k++) begin
      #1;
      total++; if (rsp_valid0 !== 1'b1 || rsp_sum0 !== 16'h0200 || rsp_id0 !== 2'd0 || req_ready0 !== 4'b0000)
        begin bad++; $display("FAIL bp_hold[%0d] got v=%b sum=%h id=%0d rdy=%b exp 1/0200/0/0000", k, rsp_valid0, rsp_sum0, rsp_id0, req_ready0); end
      step();
    end
    rsp_ready = 1'b1;
    #1;
    total++; if (req_ready0 !== 4'b0010) begin bad++; $display("FAIL bp_release_ready got=%b exp=0010", req_ready0); end
    step();
    req_valid = 4'b0000;
    total++; if (rsp_valid0 !== 1'b1 || rsp_id0 !== 2'd1 || rsp_sum0 !== 16'h0033)
      begin bad++; $display("FAIL bp_next got v=%b id=%0d sum=%h exp 1/1/0033", rsp_valid0, rsp_id0, rsp_sum0); end
    step();
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 4; i++) set_ab(i, 16'h0001, 16'(i));
    req_valid = 4'b1111; rsp_ready = 1'b0;
    step();
    total++; if (rsp_valid0 !== 1'b1 || rsp_id0 !== 2'd2)
      begin bad++; $display("FAIL mid_setup got v=%b id=%0d exp 1/2", rsp_valid0, rsp_id0); end
    rst = 1'b1; rsp_ready = 1'b1;
    #1;
    total++; if (req_ready0 !== 4'b0000) begin bad++; $display("FAIL mid_rst_ready got=%b exp=0000", req_ready0); end
    step();
    rst = 1'b0;
    #1;
    total++; if (rsp_valid0 !== 1'b0 || ovf_cnt0 !== 16'd0)
      begin bad++; $display("FAIL mid_after got v=%b cnt=%0d exp 0/0", rsp_valid0, ovf_cnt0); end
    total++; if (req_ready0 !== 4'b0001) begin bad++; $display("FAIL mid_first_ready got=%b exp=0001", req_ready0); end
    step();
    req_valid = 4'b0000;
    total++; if (rsp_id0 !== 2'd0 || rsp_sum0 !== 16'h0001)
      begin bad++; $display("FAIL mid_first_rsp got id=%0d sum=%h exp 0/0001", rsp_id0, rsp_sum0); end
    step();
  endtask

  task automatic test_cnt_saturate();
    set_ab(0, 16'h7F00, 16'h0200);
    req_valid = 4'b0001; rsp_ready = 1'b1;
    for (int k = 0; k < 20; k++) begin
      step();
      total++; if (ovf_cnt1 !== 4'((k + 1 > 15) ? 15 : k + 1))
        begin bad++; $display("FAIL sat_cnt[%0d] got=%0d exp=%0d", k, ovf_cnt1, (k + 1 > 15) ? 15 : k + 1); end
    end
    req_valid = 4'b0000;
    total++; if (ovf_cnt0 !== 16'd20) begin bad++; $display("FAIL wide_cnt got=%0d exp=20", ovf_cnt0); end
    total++; if (rsp_sum1 !== 16'h7FFF) begin bad++; $display("FAIL sat_sum got=%h exp=7fff", rsp_sum1); end
    step();
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_single();
    test_round_robin();
    test_overflow();
    test_backpressure();
    test_reset_mid();
    test_cnt_saturate();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
